// File: rtl/sram_arb_nx1.sv
// N-to-1 arbiter for the SRAM-like bus with in-order response routing.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sram_arb_nx1 #(
   parameter int N_MASTERS = 3,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 4
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [N_MASTERS-1:0]          m_req,
   input  logic [N_MASTERS-1:0]          m_wr,
   input  logic [2*N_MASTERS-1:0]        m_size,
   input  logic [ADDR_W*N_MASTERS-1:0]   m_addr,
   input  logic [DATA_W*N_MASTERS-1:0]   m_wdata,
   output logic [N_MASTERS-1:0]          m_addr_ok,
   output logic [N_MASTERS-1:0]          m_data_ok,
   output logic [DATA_W-1:0]             m_rdata,
   output logic                          s_req,
   output logic                          s_wr,
   output logic [1:0]                    s_size,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   input  logic                          s_addr_ok,
   input  logic                          s_data_ok,
   input  logic [DATA_W-1:0]             s_rdata,
   output logic [$clog2(MAX_OUTST):0]    outst_cnt,
   output logic                          err
);

   localparam int IDX_W = $clog2(N_MASTERS);
   localparam int PTR_W = $clog2(MAX_OUTST);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

   lock_state_t          state_reg, state_next;
   logic [IDX_W-1:0]     lock_idx_reg, lock_idx_next;
   logic [IDX_W-1:0]     arb_grant, grant, head_idx;
   logic [IDX_W-1:0]     fifo_mem [MAX_OUTST];
   logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic                 err_reg;
   logic                 full, empty, accept, pop;

   logic                 wr_a    [N_MASTERS];
   logic [1:0]           size_a  [N_MASTERS];
   logic [ADDR_W-1:0]    addr_a  [N_MASTERS];
   logic [DATA_W-1:0]    wdata_a [N_MASTERS];

   genvar gi;
   generate
      for (gi = 0; gi < N_MASTERS; gi++) begin : g_port
         assign wr_a[gi]      = m_wr[gi];
         assign size_a[gi]    = m_size[gi*2 +: 2];
         assign addr_a[gi]    = m_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_a[gi]   = m_wdata[gi*DATA_W +: DATA_W];
         assign m_addr_ok[gi] = accept && (grant == IDX_W'(gi));
         assign m_data_ok[gi] = pop && (head_idx == IDX_W'(gi));
      end
   endgenerate

`ifdef SRAM_ARB_FIXED_PRIO_EN
   always_comb begin
      arb_grant = '0;
      for (int k = N_MASTERS - 1; k >= 0; k--) begin
         if (m_req[k]) arb_grant = IDX_W'(k);
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic             found;
   int               cand;

   // Scan N positions starting at rr_ptr; first asserted request wins.
   always_comb begin
      arb_grant = rr_ptr_reg;
      found     = 1'b0;
      cand      = 0;
      for (int k = 0; k < N_MASTERS; k++) begin
         cand = int'(rr_ptr_reg) + k;
         if (cand >= N_MASTERS) cand = cand - N_MASTERS;
         if (!found && m_req[cand]) begin
            arb_grant = IDX_W'(cand);
            found     = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (accept) rr_ptr_next = (grant == IDX_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rr_ptr_reg <= '0;
      else          rr_ptr_reg <= rr_ptr_next;
   end
`endif

   assign grant    = (state_reg == ST_LOCKED) ? lock_idx_reg : arb_grant;
   assign full     = (cnt_reg == CNT_W'(MAX_OUTST));
   assign empty    = (cnt_reg == '0);
   assign head_idx = fifo_mem[rd_ptr_reg];

   // A locked master that drops its request simply stops driving s_req.
   assign s_req   = aresetn && !full && m_req[grant];
   assign s_wr    = wr_a[grant];
   assign s_size  = size_a[grant];
   assign s_addr  = addr_a[grant];
   assign s_wdata = wdata_a[grant];
   assign accept  = s_req && s_addr_ok;
   assign pop     = aresetn && s_data_ok && !empty;
   assign m_rdata = s_rdata;

   assign outst_cnt = cnt_reg;
   assign err       = err_reg;

   always_comb begin
      state_next    = state_reg;
      lock_idx_next = lock_idx_reg;
      case (state_reg)
         ST_OPEN: begin
            if (s_req && !s_addr_ok) begin
               state_next    = ST_LOCKED;
               lock_idx_next = grant;
            end
         end
         ST_LOCKED: begin
            if (accept || !m_req[lock_idx_reg]) state_next = ST_OPEN;
         end
         default: state_next = ST_OPEN;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg    <= ST_OPEN;
         lock_idx_reg <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         cnt_reg      <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         lock_idx_reg <= lock_idx_next;
         if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (accept && !pop)      cnt_reg <= cnt_reg + 1'b1;
         else if (!accept && pop) cnt_reg <= cnt_reg - 1'b1;
         if (s_data_ok && empty) err_reg <= 1'b1;
      end
   end

   // Order storage carries no reset: entries are only read behind the count.
   always_ff @(posedge aclk) begin
      if (accept) fifo_mem[wr_ptr_reg] <= grant;
   end

endmodule
